// File: rtl/idelay_sweep_ctrl.sv
// Tap-sweep sequencer for a VAR_LOAD/PIPE_SEL IDELAYE2: loads each tap, waits for it to settle,
// holds it for a dwell period and hands it to a downstream sampler.
module idelay_sweep_ctrl #(
  parameter int unsigned TAP_W       = 5,
  parameter int unsigned DWELL_W     = 16,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned RDY_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [TAP_W-1:0]   tap_first,
  input  logic [TAP_W-1:0]   tap_last,
  input  logic [TAP_W-1:0]   tap_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               dly_rdy,
  input  logic               sample_ack,
  output logic [TAP_W-1:0]   cntvaluein,
  output logic               ldpipeen,
  output logic               ld,
  output logic [TAP_W-1:0]   tap_cur,
  output logic               tap_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned ToW  = $clog2(RDY_TIMEOUT + 1);
  localparam int unsigned StW  = $clog2(SETTLE + 1);
  localparam int unsigned CntA = (DWELL_W > ToW) ? DWELL_W : ToW;
  localparam int unsigned CntW = (CntA > StW) ? CntA : StW;

  typedef enum logic [2:0] {
    StIdle, StWaitRdy, StLoadPipe, StLoad, StSettle, StDwell, StWaitAck, StNext
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TAP_W-1:0]   last_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [TAP_W-1:0]   tap_cur_q, tap_cur_d;
  logic [TAP_W-1:0]   cntvaluein_q, cntvaluein_d;
  logic               ldpipeen_q, ldpipeen_d, ld_q, ld_d, tap_valid_q, tap_valid_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic               start_ok, bad_cfg, timeout, rdy_lost, fin, rdy_chk;
  logic [TAP_W:0]     nxt;
  logic               nxt_end;

  assign nxt     = {1'b0, tap_cur_q} + {1'b0, step_q};
  assign nxt_end = nxt[TAP_W] | (nxt > {1'b0, last_q});
  assign rdy_chk = (state_q != StIdle) && (state_q != StWaitRdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    bad_cfg  = 1'b0;
    timeout  = 1'b0;
    rdy_lost = 1'b0;
    fin      = 1'b0;
    if ((state_q != StIdle) && abort) begin
      state_d = StIdle;
    end else if (rdy_chk && !dly_rdy) begin
      state_d  = StIdle;
      rdy_lost = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          // busy_q still high here means the done/err tail cycle; start is not yet accepted
          if (start && !busy_q) begin
            if (tap_first > tap_last) begin
              bad_cfg = 1'b1;
            end else begin
              start_ok = 1'b1;
              state_d  = StWaitRdy;
            end
          end
        end
        StWaitRdy: begin
          if (dly_rdy) begin
            state_d = StLoadPipe;
          end else if (cnt_q == CntW'(RDY_TIMEOUT - 1)) begin
            timeout = 1'b1;
            state_d = StIdle;
          end
        end
        StLoadPipe: state_d = StLoad;
        StLoad:     state_d = StSettle;
        StSettle: begin
          if (cnt_q == CntW'(SETTLE - 1)) state_d = StDwell;
        end
        StDwell: begin
          if (cnt_q == CntW'(dwell_q) - CntW'(1)) state_d = StWaitAck;
        end
        StWaitAck: begin
          if (sample_ack) state_d = StNext;
        end
        StNext: begin
          if (nxt_end) begin
            fin     = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StLoadPipe;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // All outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    cnt_d        = (state_d != state_q) ? '0 : cnt_q + CntW'(1);
    tap_cur_d    = tap_cur_q;
    if (start_ok) begin
      tap_cur_d = tap_first;
    end else if ((state_q == StNext) && (state_d == StLoadPipe)) begin
      tap_cur_d = nxt[TAP_W-1:0];
    end
    cntvaluein_d = cntvaluein_q;
    if ((state_d == StLoadPipe) && (state_q != StLoadPipe)) cntvaluein_d = tap_cur_d;
    ldpipeen_d   = (state_d == StLoadPipe);
    ld_d         = (state_d == StLoad);
    tap_valid_d  = (state_d == StDwell) || (state_d == StWaitAck);
    done_d       = fin;
    err_d        = bad_cfg | timeout | rdy_lost;
    // busy stays high for one tail cycle carrying the done/err pulse of a running sweep
    busy_d       = (state_d != StIdle) | fin | timeout | rdy_lost;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      last_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      tap_cur_q    <= '0;
      cntvaluein_q <= '0;
      ldpipeen_q   <= 1'b0;
      ld_q         <= 1'b0;
      tap_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      if (start_ok) begin
        last_q  <= tap_last;
        step_q  <= (tap_step == '0) ? TAP_W'(1) : tap_step;
        dwell_q <= (dwell == '0) ? DWELL_W'(1) : dwell;
      end
      tap_cur_q    <= tap_cur_d;
      cntvaluein_q <= cntvaluein_d;
      ldpipeen_q   <= ldpipeen_d;
      ld_q         <= ld_d;
      tap_valid_q  <= tap_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cntvaluein = cntvaluein_q;
  assign ldpipeen   = ldpipeen_q;
  assign ld         = ld_q;
  assign tap_cur    = tap_cur_q;
  assign tap_valid  = tap_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/idelay_sweep_ctrl.md
# idelay_sweep_ctrl

Sequencer for the clock-delay path in the clock/reset generator: drives the 5-bit tap value and load strobes of a VAR_LOAD, PIPE_SEL=TRUE IDELAYE2. On request, it sweeps the tap value from a start tap to an end tap with a fixed step. At each tap it holds the delayed sample clock for a programmed dwell time and hands it to a downstream sampler. The block runs in the sample-clock domain and sits between the host register interface and the IDELAYE2/IDELAYCTRL pair.

## Interface
- TAP_W, 5, tap value width (IDELAYE2 CNTVALUEIN width)
- DWELL_W, 16, dwell counter width
- SETTLE, 4, cycles waited after the load strobe before the tap is declared valid (≥1)
- RDY_TIMEOUT, 1024, cycles allowed for IDELAYCTRL RDY before error

Ports:
- clk  in  1  sample clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  sweep request, sampled only in IDLE
- abort  in  1  cancel sweep; any state returns to IDLE
- tap_first  in  TAP_W  first tap, latched at start
- tap_last  in  TAP_W  last tap (inclusive), latched at start
- tap_step  in  TAP_W  increment, latched at start; 0 is treated as 1
- dwell  in  DWELL_W  cycles per tap, latched at start; 0 is treated as 1
- dly_rdy  in  1  IDELAYCTRL RDY
- sample_ack  in  1  sampler has finished with the current tap
- cntvaluein  out  TAP_W  tap value to IDELAYE2
- ldpipeen  out  1  IDELAYE2 LDPIPEEN, 1-cycle pulse
- ld  out  1  IDELAYE2 LD, 1-cycle pulse
- tap_cur  out  TAP_W  tap currently applied
- tap_valid  out  1  delayed clock is stable at tap_cur
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse when the sweep completes normally
- err  out  1  1-cycle pulse on bad config, RDY timeout, or RDY loss

## Operation
- States: IDLE, WAIT_RDY, LOAD_PIPE, LOAD, SETTLE, DWELL, WAIT_ACK, NEXT.
- IDLE, start=1:
  - if tap_first > tap_last: pulse err and stay in IDLE.
  - otherwise latch the config, set tap_cur=tap_first, and go to WAIT_RDY.
- WAIT_RDY:
  - dly_rdy=1 → LOAD_PIPE.
  - counter reaches RDY_TIMEOUT → err pulse, IDLE.
- LOAD_PIPE: cntvaluein=tap_cur, ldpipeen=1 for one cycle → LOAD.
- LOAD: ld=1 for one cycle → SETTLE.
- SETTLE: count SETTLE cycles → DWELL.
- DWELL: tap_valid=1; count the latched dwell cycles → WAIT_ACK.
- WAIT_ACK: tap_valid=1 and is held until sample_ack=1 → NEXT.
  - sample_ack is ignored outside WAIT_ACK.
- NEXT: next = tap_cur + step, computed TAP_W+1 bits wide.
  - If next > tap_last, or next overflows 2^TAP_W-1: pulse done, go to IDLE.
  - Otherwise tap_cur=next, go to LOAD_PIPE. WAIT_RDY is not re-entered.
- dly_rdy=0 in any state from LOAD_PIPE through NEXT → err pulse, IDLE; no done.
- abort=1 in any non-IDLE state → IDLE next cycle.
  - No done, no err.
  - ld/ldpipeen low; cntvaluein and tap_cur keep their last value.
- Priority within one cycle: rst > abort > RDY loss > normal transition.
- start while busy is ignored. Config inputs may change freely after start.
- cntvaluein changes only on entry to LOAD_PIPE. It is stable for the whole LOAD_PIPE and LOAD interval.

## Timing
- Reset values: cntvaluein=0, tap_cur=0, ldpipeen=0, ld=0, tap_valid=0, busy=0, done=0, err=0; state IDLE.
- All outputs are registered.
- start at cycle n (RDY already high):
  - WAIT_RDY at n+1
  - ldpipeen at n+2
  - ld at n+3
  - tap_valid first high at n+4+SETTLE
- Per-tap cost with sample_ack already high on WAIT_ACK entry: 2 + SETTLE + dwell + 2 cycles.
- done and err are single-cycle pulses, coincident with the last busy=1 cycle. busy falls the cycle after.
- tap_valid falls in the cycle after WAIT_ACK is left or after abort.

## Test plan
- Basic sweep: first=0, last=4, step=2, dwell=3, SETTLE=4, RDY high, ack tied high.
  - ld pulses with cntvaluein 0, 2, 4.
  - tap_valid high 3+1 cycles per tap.
  - done exactly once; busy low after.
- Overflow/step: first=28, last=31, step=0 → taps 28, 29, 30, 31, then done.
  - first=30, last=31, step=5 → tap 30 only, then done.
- Bad config and timeout:
  - first=9, last=3 → err pulse, busy never high.
  - dly_rdy held 0 → err after RDY_TIMEOUT cycles, no ld ever.
- Handshake: ack withheld 20 cycles in WAIT_ACK → tap_valid stays high and no next load. An ack pulse during DWELL alone does not advance.
- Abort and RDY loss:
  - abort during SETTLE of tap 2 → IDLE next cycle, no done/err, cntvaluein holds 2.
  - dly_rdy drop in DWELL → err, IDLE.
- Reset/restart: rst mid-DWELL → all outputs at reset values next cycle. A new start then sweeps from the new tap_first.
